// File: rtl/dmem_responder.sv
// Data-memory responder for a cache front end: a fixed-latency handshake on dREN/dWEN
// with dwait, a word-addressed backing store, a bench backdoor and completed-access counters.
module dmem_responder #(
    parameter int LAT   = 2,
    parameter int DEPTH = 1024
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    input  logic        bd_WEN,
    input  logic [31:0] bd_addr,
    input  logic [31:0] bd_data,
    output logic [31:0] bd_load,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
);
    localparam int         AW    = $clog2(DEPTH);
    localparam logic [3:0] LAT_C = 4'(LAT);

    typedef enum logic { S_IDLE, S_WAIT } state_t;
    typedef enum logic { OP_READ, OP_WRITE } op_t;

    state_t        state;
    logic [3:0]    cnt;
    logic [31:0]   laddr;
    op_t           lop;
    logic [31:0]   mem [DEPTH];

    logic          req;
    op_t           op;
    logic          same;
    logic          ack;
    logic [AW-1:0] idx;
    logic [AW-1:0] bd_idx;
    logic          unused_addr_bits;

    assign req    = dREN | dWEN;
    assign op     = dWEN ? OP_WRITE : OP_READ;
    assign same   = (daddr == laddr) && (op == lop);
    assign idx    = daddr[AW+1:2];
    assign bd_idx = bd_addr[AW+1:2];

    assign unused_addr_bits = ^{daddr[31:AW+2], daddr[1:0], bd_addr[31:AW+2], bd_addr[1:0]};

    // NOTE: ack must react to the request presented in this very cycle (a dropped or
    // changed request cancels it), so dwait/dload are decoded combinationally from state.
    always_comb begin
        ack = 1'b0;
        if (!RST && req) begin
            if (LAT == 0) ack = (state == S_IDLE);
            else          ack = (state == S_WAIT) && same && (cnt == LAT_C);
        end
    end

    assign dwait   = ~ack;
    assign dload   = (ack && op == OP_READ) ? mem[idx] : '0;
    assign bd_load = mem[bd_idx];

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            cnt      <= '0;
            laddr    <= '0;
            lop      <= OP_READ;
            rd_count <= '0;
            wr_count <= '0;
        end else if (ack) begin
            state <= S_IDLE;
            cnt   <= '0;
            if (op == OP_WRITE) begin
                if (wr_count != '1) wr_count <= wr_count + 32'd1;
            end else begin
                if (rd_count != '1) rd_count <= rd_count + 32'd1;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        laddr <= daddr;
                        lop   <= op;
                        cnt   <= 4'd1;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!req) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else if (!same) begin
                        laddr <= daddr;
                        lop   <= op;
                        cnt   <= 4'd1;
                    end else if (cnt < LAT_C) begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // NOTE: the storage array has no reset; its contents survive RST and it maps onto RAM.
    // The front-end write is issued last so it wins a same-index collision with the backdoor.
    always_ff @(posedge CLK) begin
        if (bd_WEN) mem[bd_idx] <= bd_data;
        if (ack && op == OP_WRITE) mem[idx] <= dstore;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LAT 2, 3, 0) share one stimulus stream;
// directed vectors for the handshake corners, then random traffic against a request-age model.
module tb_dmem_responder;
    logic        CLK = 1'b0;
    logic        RST;
    logic        dREN, dWEN, bd_WEN;
    logic [31:0] daddr, dstore, bd_addr, bd_data;

    logic        dwait_o    [3];
    logic [31:0] dload_o    [3];
    logic [31:0] bd_load_o  [3];
    logic [31:0] rd_count_o [3];
    logic [31:0] wr_count_o [3];

    localparam int LAT_OF [3] = '{2, 3, 0};

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(.LAT(g == 0 ? 2 : (g == 1 ? 3 : 0)), .DEPTH(1024)) u_dut (
            .CLK(CLK), .RST(RST), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
            .dwait(dwait_o[g]), .dload(dload_o[g]),
            .bd_WEN(bd_WEN), .bd_addr(bd_addr), .bd_data(bd_data), .bd_load(bd_load_o[g]),
            .rd_count(rd_count_o[g]), .wr_count(wr_count_o[g])
        );
    end

    typedef struct {
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] data;
        logic        exp_wait;
        logic [31:0] exp_load;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs just after the falling edge; outputs are sampled 1 ns later.
    task automatic drive(input logic ren, input logic wen, input logic [31:0] addr,
                         input logic [31:0] data, input logic bwen,
                         input logic [31:0] baddr, input logic [31:0] bdata);
        @(negedge CLK);
        dREN = ren; dWEN = wen; daddr = addr; dstore = data;
        bd_WEN = bwen; bd_addr = baddr; bd_data = bdata;
        #1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1; dREN = 1'b1; dWEN = 1'b1; daddr = 32'h40; dstore = 32'hFFFF; bd_WEN = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_dwait%0d", i), 32'(dwait_o[i]), 32'd1);
            check($sformatf("rst_dload%0d", i), dload_o[i], 32'd0);
        end
        @(negedge CLK);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_rd_count%0d", i), rd_count_o[i], 32'd0);
            check($sformatf("rst_wr_count%0d", i), wr_count_o[i], 32'd0);
        end
        RST = 1'b0; dREN = 1'b0; dWEN = 1'b0; daddr = 32'h0; dstore = 32'h0;
        #1;
    endtask

    vec_t        tbl [8];
    int          ack_cyc [2];
    int          acks;
    logic [31:0] mm [3][16];
    int          age [3];
    bit          pv [3];
    logic [31:0] paddr [3];
    bit          pop [3];
    int          rc [3], wc [3];

    initial begin
        RST = 1'b1; dREN = 1'b0; dWEN = 1'b0; daddr = '0; dstore = '0;
        bd_WEN = 1'b0; bd_addr = '0; bd_data = '0;

        // Read then write with LAT=2 (instance 0)
        tbl[0] = '{1'b1, 1'b0, 32'h40, 32'h0,        1'b1, 32'h0};
        tbl[1] = '{1'b1, 1'b0, 32'h40, 32'h0,        1'b1, 32'h0};
        tbl[2] = '{1'b1, 1'b0, 32'h40, 32'h0,        1'b0, 32'hDEADBEEF};
        tbl[3] = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 32'h0};
        tbl[4] = '{1'b0, 1'b1, 32'h80, 32'h12345678, 1'b1, 32'h0};
        tbl[5] = '{1'b0, 1'b1, 32'h80, 32'h12345678, 1'b1, 32'h0};
        tbl[6] = '{1'b0, 1'b1, 32'h80, 32'h12345678, 1'b0, 32'h0};
        tbl[7] = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 32'h0};

        do_reset();
        drive(0, 0, 0, 0, 1, 32'h40, 32'hDEADBEEF);
        for (int v = 0; v < 8; v++) begin
            drive(tbl[v].ren, tbl[v].wen, tbl[v].addr, tbl[v].data, 0, 32'h80, 0);
            check($sformatf("tbl%0d_dwait", v), 32'(dwait_o[0]), 32'(tbl[v].exp_wait));
            check($sformatf("tbl%0d_dload", v), dload_o[0], tbl[v].exp_load);
        end
        check("tbl_bd_load_80", bd_load_o[0], 32'h12345678);
        check("tbl_rd_count", rd_count_o[0], 32'd1);
        check("tbl_wr_count", wr_count_o[0], 32'd1);

        // Back-to-back block write 0x100, 0x104 with LAT=2: six cycles end to end
        do_reset();
        ack_cyc = '{-1, -1};
        acks = 0;
        for (int k = 0; k < 20 && acks < 2; k++) begin
            drive(0, 1, acks == 0 ? 32'h100 : 32'h104, acks == 0 ? 32'hA0A00100 : 32'hB0B00104, 0, 0, 0);
            if (!dwait_o[0]) begin
                ack_cyc[acks] = k;
                acks++;
            end
        end
        check("b2b_first_ack", 32'(ack_cyc[0]), 32'd2);
        check("b2b_second_ack", 32'(ack_cyc[1]), 32'd5);
        drive(0, 0, 0, 0, 0, 32'h100, 0);
        check("b2b_word0", bd_load_o[0], 32'hA0A00100);
        drive(0, 0, 0, 0, 0, 32'h104, 0);
        check("b2b_word1", bd_load_o[0], 32'hB0B00104);
        check("b2b_wr_count", wr_count_o[0], 32'd2);

        // Address change mid-wait with LAT=3 (instance 1) restarts the count
        do_reset();
        ack_cyc[0] = -1;
        acks = 0;
        for (int k = 0; k < 10; k++) begin
            drive(acks == 0, 0, k < 2 ? 32'h200 : 32'h204, 0, 0, 0, 0);
            if (!dwait_o[1]) begin
                if (acks == 0) ack_cyc[0] = k;
                acks++;
            end
        end
        check("restart_ack_cycle", 32'(ack_cyc[0]), 32'd5);
        check("restart_ack_total", 32'(acks), 32'd1);
        check("restart_rd_count", rd_count_o[1], 32'd1);

        // Reset in the middle of a write (LAT=2), memory survives reset
        drive(0, 0, 0, 0, 1, 32'h300, 32'hAAAA5555);
        do_reset();
        drive(0, 0, 0, 0, 0, 32'h40, 0);
        check("mem_survives_reset", bd_load_o[0], 32'hDEADBEEF);
        drive(0, 1, 32'h300, 32'h77, 0, 32'h300, 0);
        check("rstmid_c0_dwait", 32'(dwait_o[0]), 32'd1);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check("rstmid_c1_dwait", 32'(dwait_o[0]), 32'd1);
        drive(0, 1, 32'h300, 32'h77, 0, 32'h300, 0);
        RST = 1'b0;
        #1;
        check("rstmid_c2_dwait", 32'(dwait_o[0]), 32'd1);
        drive(0, 0, 0, 0, 0, 32'h300, 0);
        check("rstmid_mem", bd_load_o[0], 32'hAAAA5555);
        check("rstmid_wr_count", wr_count_o[0], 32'd0);
        check("rstmid_idle_dwait", 32'(dwait_o[0]), 32'd1);
        ack_cyc[0] = -1;
        for (int k = 0; k < 10 && ack_cyc[0] < 0; k++) begin
            drive(1, 0, 32'h300, 0, 0, 0, 0);
            if (!dwait_o[0]) begin
                ack_cyc[0] = k;
                check("post_rst_read_data", dload_o[0], 32'hAAAA5555);
            end
        end
        check("post_rst_read_ack", 32'(ack_cyc[0]), 32'd2);

        // LAT=0 (instance 2): same-cycle ack, dWEN priority, collision, read-during-write
        do_reset();
        drive(1, 1, 32'h10, 32'h5, 0, 0, 0);
        check("lat0_dwait", 32'(dwait_o[2]), 32'd0);
        check("lat0_dload_write", dload_o[2], 32'd0);
        drive(0, 0, 0, 0, 0, 32'h10, 0);
        check("lat0_stored", bd_load_o[2], 32'h5);
        check("lat0_wr_count", wr_count_o[2], 32'd1);
        check("lat0_rd_count", rd_count_o[2], 32'd0);
        drive(0, 1, 32'h14, 32'h66, 1, 32'h14, 32'h99);
        check("collide_dwait", 32'(dwait_o[2]), 32'd0);
        drive(0, 0, 0, 0, 0, 32'h14, 0);
        check("collide_front_wins", bd_load_o[2], 32'h66);
        drive(1, 0, 32'h10, 0, 1, 32'h10, 32'h7);
        check("rdw_dload_old", dload_o[2], 32'h5);
        check("rdw_bd_load_old", bd_load_o[2], 32'h5);
        drive(0, 0, 0, 0, 0, 32'h10, 0);
        check("rdw_bd_load_new", bd_load_o[2], 32'h7);

        // Random traffic against a request-age model, all three latencies at once
        do_reset();
        for (int w = 0; w < 16; w++) begin
            logic [31:0] d;
            d = $urandom;
            drive(0, 0, 0, 0, 1, 32'(w) << 2, d);
            for (int i = 0; i < 3; i++) mm[i][w] = d;
        end
        for (int i = 0; i < 3; i++) begin
            age[i] = 0; pv[i] = 0; paddr[i] = '0; pop[i] = 0; rc[i] = 0; wc[i] = 0;
        end
        begin
            logic        cr, cw, bw;
            logic [31:0] ca, cd, bdat;
            logic [3:0]  bidx, ridx;
            logic [1:0]  r;
            cr = 0; cw = 0; ca = 0;
            for (int t = 0; t < 600; t++) begin
                if (t == 0 || $urandom_range(0, 3) == 0) begin
                    r  = 2'($urandom_range(0, 3));
                    cr = r[0];
                    cw = r[1];
                    ca = ($urandom_range(0, 3) << 20) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
                end
                cd   = $urandom;
                bw   = ($urandom_range(0, 7) == 0);
                bidx = 4'($urandom_range(0, 15));
                bdat = $urandom;
                drive(cr, cw, ca, cd, bw, 32'(bidx) << 2, bdat);
                ridx = ca[5:2];
                for (int i = 0; i < 3; i++) begin
                    bit req, op, ack;
                    int a;
                    req = cr | cw;
                    op  = cw;
                    a   = (pv[i] && ca == paddr[i] && op == pop[i]) ? age[i] + 1 : 0;
                    ack = req && (a == LAT_OF[i]);
                    check($sformatf("rnd%0d_dwait%0d", t, i), 32'(dwait_o[i]), 32'(!ack));
                    check($sformatf("rnd%0d_dload%0d", t, i), dload_o[i], (ack && !op) ? mm[i][ridx] : 32'd0);
                    check($sformatf("rnd%0d_bd_load%0d", t, i), bd_load_o[i], mm[i][bidx]);
                    if (bw) mm[i][bidx] = bdat;
                    if (ack && op) mm[i][ridx] = cd;
                    if (ack) begin
                        if (op) wc[i]++;
                        else    rc[i]++;
                    end
                    pv[i]    = req && !ack;
                    paddr[i] = ca;
                    pop[i]   = op;
                    age[i]   = a;
                end
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rnd_rd_count%0d", i), rd_count_o[i], 32'(rc[i]));
            check($sformatf("rnd_wr_count%0d", i), wr_count_o[i], 32'(wc[i]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
